// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_pkg : shared encodings and constants for the pipeline
//                        controller and the stage registers.
// Revision 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

   // E-stage multiply/divide operation encoding
   localparam logic [1:0] MD_NONE = 2'b00;
   localparam logic [1:0] MD_MULT = 2'b01;
   localparam logic [1:0] MD_DIV  = 2'b10;
   localparam logic [1:0] MD_MT   = 2'b11;

   localparam int MULT_CYC_DEF = 5;
   localparam int DIV_CYC_DEF  = 10;
   localparam int CNT_W_DEF    = 4;

   // PC targets used by the stage registers
   localparam logic [31:0] EXC_HANDLER_PC = 32'h0000_4180;
   localparam logic [31:0] RESET_PC       = 32'h0000_3000;

   // True when the E-stage op actually occupies the MDU for several cycles
   function automatic logic is_md_start_op(input logic [1:0] op);
      return (op == MD_MULT) || (op == MD_DIV);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_md_busy_counter.sv
`default_nettype none
// ============================================================================
// md_busy_counter : multi-cycle MDU busy counter; reload on start, count down.
// Revision 1.0
// ============================================================================
module md_busy_counter
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] op,
   output logic       busy
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] load_val;

   assign load_val = (op == MD_DIV) ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);

   // A start while still counting simply reloads; decode normally prevents it.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (start) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign busy = ~reset & (start | (cnt != '0));

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : stall/flush generation, MDU sequencing and EXL tracking
//                    for the 5-stage MIPS pipeline.
// Revision 1.0
// ============================================================================
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYC = MULT_CYC_DEF,
   parameter int DIV_CYC  = DIV_CYC_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] D_rs,
   input  logic [4:0] D_rt,
   input  logic       D_rs_use,
   input  logic       D_rt_use,
   input  logic [1:0] D_Tuse_rs,
   input  logic [1:0] D_Tuse_rt,
   input  logic       D_md_use,
   input  logic [4:0] E_A3,
   input  logic [4:0] M_A3,
   input  logic [1:0] E_Tnew,
   input  logic [1:0] M_Tnew,
   input  logic [1:0] E_md_op,
   input  logic       M_exc,
   input  logic       M_eret,
   input  logic [5:0] irq,
   input  logic [5:0] im,
   input  logic       ie,
   output logic       Stall,
   output logic       Req,
   output logic       md_start,
   output logic       md_busy,
   output logic       exl
);

   logic rs_stall;
   logic rt_stall;
   logic md_stall;
   logic int_pending;

   // A producer only blocks when its result arrives later than the consumer needs it
   assign rs_stall = D_rs_use && (D_rs != 5'd0) &&
                     (((D_rs == E_A3) && (E_Tnew > D_Tuse_rs)) ||
                      ((D_rs == M_A3) && (M_Tnew > D_Tuse_rs)));

   assign rt_stall = D_rt_use && (D_rt != 5'd0) &&
                     (((D_rt == E_A3) && (E_Tnew > D_Tuse_rt)) ||
                      ((D_rt == M_A3) && (M_Tnew > D_Tuse_rt)));

   assign int_pending = (|(irq & im)) & ie & ~exl;

   assign Req      = ~reset & (M_exc | int_pending);
   assign md_start = ~reset & ~Req & is_md_start_op(E_md_op);
   assign md_stall = D_md_use & md_busy;

   // Flush wins: the stage registers would otherwise hold the PC on Stall
   assign Stall = ~reset & ~Req & (rs_stall | rt_stall | md_stall);

   md_busy_counter #(
      .MULT_CYC (MULT_CYC),
      .DIV_CYC  (DIV_CYC),
      .CNT_W    (CNT_W)
   ) u_md_busy_counter (
      .clk   (clk),
      .reset (reset),
      .start (md_start),
      .op    (E_md_op),
      .busy  (md_busy)
   );

   // Entering the handler outranks a concurrent eret
   always_ff @(posedge clk) begin
      if (reset) begin
         exl <= 1'b0;
      end else if (Req) begin
         exl <= 1'b1;
      end else if (M_eret) begin
         exl <= 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : directed self-checking bench for pipe_hazard_ctrl.
// Revision 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] D_rs, D_rt, E_A3, M_A3;
   logic       D_rs_use, D_rt_use, D_md_use;
   logic [1:0] D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew, E_md_op;
   logic       M_exc, M_eret, ie;
   logic [5:0] irq, im;
   logic       Stall, Req, md_start, md_busy, exl;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .D_rs      (D_rs),
      .D_rt      (D_rt),
      .D_rs_use  (D_rs_use),
      .D_rt_use  (D_rt_use),
      .D_Tuse_rs (D_Tuse_rs),
      .D_Tuse_rt (D_Tuse_rt),
      .D_md_use  (D_md_use),
      .E_A3      (E_A3),
      .M_A3      (M_A3),
      .E_Tnew    (E_Tnew),
      .M_Tnew    (M_Tnew),
      .E_md_op   (E_md_op),
      .M_exc     (M_exc),
      .M_eret    (M_eret),
      .irq       (irq),
      .im        (im),
      .ie        (ie),
      .Stall     (Stall),
      .Req       (Req),
      .md_start  (md_start),
      .md_busy   (md_busy),
      .exl       (exl)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      D_rs = 0; D_rt = 0; D_rs_use = 0; D_rt_use = 0;
      D_Tuse_rs = 0; D_Tuse_rt = 0; D_md_use = 0;
      E_A3 = 0; M_A3 = 0; E_Tnew = 0; M_Tnew = 0; E_md_op = 0;
      M_exc = 0; M_eret = 0; irq = 0; im = 0; ie = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b1;
      E_md_op = 2'b10; M_exc = 1'b1; E_A3 = 5'd3; E_Tnew = 2'd2;
      D_rs = 5'd3; D_rs_use = 1'b1; D_md_use = 1'b1;
      step(); step();
      #1;
      checks++;
      if ({Stall, Req, md_start, md_busy, exl} !== 5'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b expected 00000", {Stall, Req, md_start, md_busy, exl});
      end
      clear_inputs();
      reset = 1'b0;
      step();
      checks++;
      if ({Stall, Req, md_start, md_busy, exl} !== 5'b0) begin
         errors++;
         $display("FAIL after_reset: got %b expected 00000", {Stall, Req, md_start, md_busy, exl});
      end
   endtask

   task automatic test_load_use();
      clear_inputs();
      E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_use = 1'b1; D_Tuse_rs = 2'd0;
      #1; checks++;
      if (Stall !== 1'b1) begin errors++; $display("FAIL load_use_E: Stall=%b expected 1", Stall); end
      step();
      E_Tnew = 2'd0; M_A3 = 5'd8; M_Tnew = 2'd1;
      #1; checks++;
      if (Stall !== 1'b1) begin errors++; $display("FAIL load_use_M: Stall=%b expected 1", Stall); end
      step();
      M_Tnew = 2'd0;
      #1; checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL load_use_clear: Stall=%b expected 0", Stall); end
      // rt path at the Tnew == Tuse boundary, then one cycle late
      clear_inputs();
      D_rt = 5'd9; D_rt_use = 1'b1; E_A3 = 5'd9; E_Tnew = 2'd1; D_Tuse_rt = 2'd1;
      #1; checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL rt_equal_tnew: Stall=%b expected 0", Stall); end
      D_Tuse_rt = 2'd0;
      #1; checks++;
      if (Stall !== 1'b1) begin errors++; $display("FAIL rt_late: Stall=%b expected 1", Stall); end
      step();
   endtask

   task automatic test_zero_and_nouse();
      clear_inputs();
      E_A3 = 5'd0; E_Tnew = 2'd2; D_rs = 5'd0; D_rs_use = 1'b1;
      #1; checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL reg_zero: Stall=%b expected 0", Stall); end
      E_A3 = 5'd8; D_rs = 5'd8; D_rs_use = 1'b0;
      #1; checks++;
      if (Stall !== 1'b0) begin errors++; $display("FAIL no_use: Stall=%b expected 0", Stall); end
      step();
   endtask

   task automatic test_md_busy(input logic [1:0] op, input int cycles, input string name);
      clear_inputs();
      E_md_op = op;
      #1; checks++;
      if (md_start !== 1'b1 || md_busy !== 1'b1) begin
         errors++;
         $display("FAIL %s_start: md_start=%b md_busy=%b expected 1 1", name, md_start, md_busy);
      end
      step();
      E_md_op = 2'b00; D_md_use = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         #1; checks++;
         if (Stall !== 1'b1 || md_start !== 1'b0) begin
            errors++;
            $display("FAIL %s_busy_cycle%0d: Stall=%b md_start=%b expected 1 0", name, i + 1, Stall, md_start);
         end
         step();
      end
      #1; checks++;
      if (Stall !== 1'b0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_done: Stall=%b md_busy=%b expected 0 0", name, Stall, md_busy);
      end
      D_md_use = 1'b0;
      E_md_op = 2'b11;
      #1; checks++;
      if (md_start !== 1'b0 || md_busy !== 1'b0) begin
         errors++;
         $display("FAIL %s_mt_no_start: md_start=%b md_busy=%b expected 0 0", name, md_start, md_busy);
      end
      step();
      E_md_op = 2'b00;
      #1; checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL %s_mt_idle: md_busy=%b expected 0", name, md_busy); end
   endtask

   task automatic test_interrupt();
      clear_inputs();
      irq = 6'b000100; im = 6'b000100; ie = 1'b1;
      #1; checks++;
      if (Req !== 1'b1 || exl !== 1'b0) begin errors++; $display("FAIL irq_req: Req=%b exl=%b expected 1 0", Req, exl); end
      step(); checks++;
      if (Req !== 1'b0 || exl !== 1'b1) begin errors++; $display("FAIL irq_masked: Req=%b exl=%b expected 0 1", Req, exl); end
      M_eret = 1'b1;
      #1; checks++;
      if (Req !== 1'b0) begin errors++; $display("FAIL eret_cycle: Req=%b expected 0", Req); end
      step();
      M_eret = 1'b0;
      #1; checks++;
      if (Req !== 1'b1 || exl !== 1'b0) begin errors++; $display("FAIL irq_again: Req=%b exl=%b expected 1 0", Req, exl); end
      step();
      irq = 6'b0;
      // exception while in handler, together with eret: exl must stay set
      M_exc = 1'b1; M_eret = 1'b1;
      #1; checks++;
      if (Req !== 1'b1) begin errors++; $display("FAIL exc_in_exl: Req=%b expected 1", Req); end
      step();
      M_exc = 1'b0; M_eret = 1'b0;
      #1; checks++;
      if (exl !== 1'b1) begin errors++; $display("FAIL req_eret_same: exl=%b expected 1", exl); end
      // irq masked by im, then by ie
      M_eret = 1'b1; step(); M_eret = 1'b0;
      irq = 6'b000100; im = 6'b000010; ie = 1'b1;
      #1; checks++;
      if (Req !== 1'b0) begin errors++; $display("FAIL im_mask: Req=%b expected 0", Req); end
      im = 6'b000100; ie = 1'b0;
      #1; checks++;
      if (Req !== 1'b0) begin errors++; $display("FAIL ie_mask: Req=%b expected 0", Req); end
      step();
   endtask

   task automatic test_priority();
      clear_inputs();
      E_A3 = 5'd8; E_Tnew = 2'd2; D_rs = 5'd8; D_rs_use = 1'b1;
      M_exc = 1'b1; E_md_op = 2'b01;
      #1; checks++;
      if (Req !== 1'b1 || Stall !== 1'b0 || md_start !== 1'b0) begin
         errors++;
         $display("FAIL priority: Req=%b Stall=%b md_start=%b expected 1 0 0", Req, Stall, md_start);
      end
      step();
      clear_inputs();
      #1; checks++;
      if (md_busy !== 1'b0 || exl !== 1'b1) begin
         errors++;
         $display("FAIL priority_cnt: md_busy=%b exl=%b expected 0 1", md_busy, exl);
      end
      M_eret = 1'b1; step(); M_eret = 1'b0;
      // flush mid-multiply: the counter keeps running to completion
      E_md_op = 2'b01; step(); E_md_op = 2'b00;
      M_exc = 1'b1;
      #1; checks++;
      if (md_busy !== 1'b1 || md_start !== 1'b0) begin
         errors++;
         $display("FAIL req_mid_mdu: md_busy=%b md_start=%b expected 1 0", md_busy, md_start);
      end
      step(); M_exc = 1'b0;
      step(); step(); step();
      #1; checks++;
      if (md_busy !== 1'b1) begin errors++; $display("FAIL mid_mdu_last: md_busy=%b expected 1", md_busy); end
      step(); checks++;
      if (md_busy !== 1'b0) begin errors++; $display("FAIL mid_mdu_end: md_busy=%b expected 0", md_busy); end
      M_eret = 1'b1; step(); M_eret = 1'b0;
   endtask

   task automatic test_reset_mid_div();
      clear_inputs();
      M_exc = 1'b1; step(); M_exc = 1'b0;
      E_md_op = 2'b10; step(); E_md_op = 2'b00;
      D_md_use = 1'b1;
      step(); step(); step(); step();
      #1; checks++;
      if (Stall !== 1'b1 || exl !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: Stall=%b exl=%b expected 1 1", Stall, exl);
      end
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1; checks++;
      if (md_busy !== 1'b0 || exl !== 1'b0 || Stall !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_div: md_busy=%b exl=%b Stall=%b expected 0 0 0", md_busy, exl, Stall);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_zero_and_nouse();
      test_md_busy(2'b10, 10, "div");
      test_md_busy(2'b01, 5, "mult");
      test_interrupt();
      test_priority();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage MIPS core.
- Generates the Stall bubble request and the Req exception/interrupt flush consumed by the D/E pipeline registers and all other stage registers.
- Sequences the multi-cycle multiply/divide unit (MDU) with a busy counter and tracks the EXL exception-level state.
- Sits between decode/E/M stage control outputs and the stage registers, the MDU and CP0.

Parameters:
- MULT_CYC, 5, busy cycles after a mult/multu start.
- DIV_CYC, 10, busy cycles after a div/divu start.
- CNT_W, 4, width of the MDU busy counter; must hold DIV_CYC.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- D_rs, D_rt  in  5 each  D-stage source register numbers.
- D_rs_use, D_rt_use  in  1 each  source is read by the D instruction.
- D_Tuse_rs, D_Tuse_rt  in  2 each  cycles until the value is needed (0..2).
- D_md_use  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo.
- E_A3, M_A3  in  5 each  destination register in E/M (0 = none).
- E_Tnew, M_Tnew  in  2 each  cycles until the result is available.
- E_md_op  in  2  00 none, 01 mult(u), 10 div(u), 11 mthi/mtlo.
- M_exc  in  1  M-stage instruction raised an exception.
- M_eret  in  1  eret retiring in M.
- irq  in  6  external interrupt lines, level.
- im  in  6  CP0 SR interrupt mask.
- ie  in  1  CP0 SR global interrupt enable.
- Stall  out  1  insert bubble into E and freeze PC/F/D.
- Req  out  1  flush all stage registers and redirect PC to 0x00004180.
- md_start  out  1  MDU start strobe, 1 cycle.
- md_busy  out  1  MDU busy.
- exl  out  1  exception level flag.

Behaviour:
- Reset: cnt=0, exl=0. All outputs 0 in the cycle after reset and while reset is held. Stall and Req are forced to 0 while reset=1.
- Data hazard, combinational:
  - rs_stall = D_rs_use & D_rs!=0 & ((D_rs==E_A3 & E_Tnew>D_Tuse_rs) | (D_rs==M_A3 & M_Tnew>D_Tuse_rs)).
  - rt_stall is the same with the rt signals.
  - Register $0 never stalls.
- MDU:
  - md_start = (E_md_op==01 | E_md_op==10) & ~Req.
  - On the clk edge with md_start, cnt <= MULT_CYC or DIV_CYC according to the op. Otherwise cnt decrements if nonzero.
  - md_busy = md_start | (cnt!=0).
  - md_stall = D_md_use & md_busy.
  - mthi/mtlo (11) does not start the counter.
  - A start is not accepted while cnt!=0 in practice, because md_stall prevents any MDU instruction from entering E. If it occurs anyway, the counter reloads.
- Stall = (rs_stall | rt_stall | md_stall) & ~Req. Req overrides Stall, because the stage registers give Stall priority for PC capture.
- Req:
  - Req = M_exc | (|(irq & im) & ie & ~exl). Combinational, same-cycle flush.
  - exl: set to 1 on the edge where Req=1. Cleared on the edge where M_eret=1 and Req=0.
  - Req and M_eret in the same cycle: exl stays 1.
  - While exl=1, interrupts are masked. M_exc still raises Req.
- Req mid-MDU: the counter keeps running, so an in-flight operation completes. md_start is suppressed that cycle.
- Latency: hazard and Req outputs are combinational, 0 cycles. md_busy falls exactly N cycles after the start edge, where N is MULT_CYC or DIV_CYC.

Decomposition:
- Shared package holds the constants:
  - MD_NONE, MD_MULT, MD_DIV, MD_MT encodings.
  - MULT_CYC and DIV_CYC defaults.
  - Handler address 0x00004180 and reset PC 0x00003000, used by the stage registers.
- One natural sub-module: md_busy_counter, holding the counter, load and decrement logic, and md_busy.
- Hazard comparison and Req/exl logic stay in the top.

Test Plan:
- Load-use:
  - Stimulus: E_A3=8, E_Tnew=2, D_rs=8, D_rs_use=1, D_Tuse_rs=0.
  - Required: Stall=1. Next cycle E_Tnew=0, M_A3=8, M_Tnew=1 gives Stall=1 again. Then M_Tnew=0 gives Stall=0.
- $0 and no-use: E_A3=0 with D_rs=0 gives Stall=0. D_rs_use=0 with a matching register also gives Stall=0.
- Div busy:
  - Stimulus: E_md_op=10 for one cycle, then D_md_use=1 held.
  - Required: md_start=1 in the start cycle; Stall=1 for 10 cycles after the start edge; Stall=0 on the 11th cycle.
  - A mult start instead yields 5 stall cycles.
- Interrupt:
  - Stimulus: irq=000100, im=000100, ie=1, exl=0.
  - Required: Req=1 for one cycle, then exl=1 and Req=0 with irq still high. M_eret=1 clears exl, and Req=1 again the next cycle.
- Priority: rs_stall condition and M_exc=1 in the same cycle give Req=1 and Stall=0. E_md_op=01 in the same cycle gives md_start=0 and cnt unchanged.
- Reset mid-div: reset=1 with cnt=6 gives cnt=0 and md_busy=0, exl=0 and Stall=0 on the next cycle.
